// File: rtl/layer_scheduler.sv
// Sequences a chain of layers one at a time, with a mandatory idle gap between
// layers, a per-layer watchdog, abort, and a busy-cycle counter.
module layer_scheduler #(
    parameter int NUM_LAYERS  = 18,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int IDX_W       = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] skip_mask,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [IDX_W-1:0]      err_layer,
    output logic [IDX_W-1:0]      cur_layer,
    output logic [31:0]           run_cycles
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, GAP, FINISH, ERROR} state_t;

    state_t                  state, state_d;
    logic [NUM_LAYERS-1:0]   mask_q, mask_d;
    logic [WD_W-1:0]         wdog, wdog_d;
    logic [IDX_W-1:0]        cur_d, err_d;
    logic [31:0]             run_d;
    logic [NUM_LAYERS-1:0]   ls_d;
    logic                    busy_d, done_d, error_d;

    logic                    first_found, nxt_found;
    logic [IDX_W-1:0]        first_idx, nxt_idx;

    // Lowest non-skipped layer in the incoming mask, and lowest non-skipped
    // layer strictly above cur_layer in the latched mask (no wrap).
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (!skip_mask[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (!mask_q[i] && (i > int'(cur_layer))) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(i);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask_q      <= '0;
            wdog        <= '0;
            cur_layer   <= '0;
            err_layer   <= '0;
            run_cycles  <= '0;
            layer_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_d;
            mask_q      <= mask_d;
            wdog        <= wdog_d;
            cur_layer   <= cur_d;
            err_layer   <= err_d;
            run_cycles  <= run_d;
            layer_start <= ls_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d = state;
        mask_d  = mask_q;
        wdog_d  = wdog;
        cur_d   = cur_layer;
        err_d   = err_layer;
        run_d   = run_cycles;

        if ((state == ISSUE || state == GAP) && run_cycles != 32'hFFFF_FFFF)
            run_d = run_cycles + 32'd1;
        if (state == ISSUE)
            wdog_d = wdog + WD_W'(1);

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE, FINISH, ERROR: begin
                    if (start) begin
                        mask_d  = skip_mask;
                        err_d   = '0;
                        run_d   = '0;
                        wdog_d  = '0;
                        cur_d   = first_idx;
                        state_d = first_found ? ISSUE : FINISH;
                    end
                end
                ISSUE: begin
                    // done takes priority over a watchdog expiring in the same cycle
                    if (layer_done[cur_layer]) begin
                        if (nxt_found) begin
                            state_d = GAP;
                            cur_d   = nxt_idx;
                        end else begin
                            state_d = FINISH;
                        end
                    end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                        state_d = ERROR;
                        err_d   = cur_layer;
                    end
                end
                GAP: begin
                    state_d = ISSUE;
                    wdog_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        ls_d = '0;
        if (state_d == ISSUE) begin
            for (int i = 0; i < NUM_LAYERS; i++)
                ls_d[i] = (IDX_W'(i) == cur_d);
        end
        busy_d  = (state_d == ISSUE) || (state_d == GAP);
        done_d  = (state_d == FINISH);
        error_d = (state_d == ERROR);
    end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 18, giving the number of sequenced layers (index 0 runs first).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2_000_000, giving the maximum cycles a layer may stay in flight.
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_LAYERS), giving the layer-index width.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request to run the whole network.
REQ-007 SHALL have port abort, input, 1: cancels the current run.
REQ-008 SHALL have port skip_mask, input, NUM_LAYERS: a 1 bypasses that layer.
REQ-009 SHALL have port layer_start, output, NUM_LAYERS: one-hot level start to each layer.
REQ-010 SHALL have port layer_done, input, NUM_LAYERS: done from each layer.
REQ-011 SHALL have port busy, output, 1: a run is in progress.
REQ-012 SHALL have port done, output, 1: the run completed.
REQ-013 SHALL have port error, output, 1: the run stopped on a timeout.
REQ-014 SHALL have port err_layer, output, IDX_W: index of the layer that timed out.
REQ-015 SHALL have port cur_layer, output, IDX_W: index of the active layer.
REQ-016 SHALL have port run_cycles, output, 32: busy-cycle count of the last or current run.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, GAP, FINISH and ERROR; all outputs SHALL be registered.
REQ-018 SHALL accept start only in IDLE, FINISH or ERROR; start SHALL be ignored while busy.
REQ-019 On accepting start, the block SHALL:
- latch skip_mask;
- clear done, error, err_layer and run_cycles;
- set cur_layer to the lowest non-skipped index;
- go to ISSUE on the next cycle.
REQ-020 If every layer is skipped at acceptance, the block SHALL go directly to FINISH on the next cycle.
REQ-021 In ISSUE, layer_start[cur_layer] SHALL be 1 and all other bits 0; the bit SHALL be held until layer_done[cur_layer] is sampled high.
REQ-022 Latency: start accepted in cycle N SHALL give layer_start[first] high in cycle N+1.
REQ-023 Handoff: layer_done[cur_layer] high in cycle M SHALL give all layer_start bits 0 in cycle M+1 (GAP).
REQ-024 After a GAP, the next non-skipped layer's start SHALL rise in cycle M+2.
REQ-025 The GAP cycle SHALL be mandatory even when the next layer is adjacent.
REQ-026 When the finishing layer is the highest non-skipped index, the block SHALL enter FINISH in cycle M+1, skipping GAP.
REQ-027 layer_done bits other than cur_layer SHALL be ignored in all states.
REQ-028 layer_done SHALL be ignored outside ISSUE.
REQ-029 A per-layer watchdog SHALL clear on entry to ISSUE and increment each ISSUE cycle.
REQ-030 If the watchdog reaches TIMEOUT_CYC-1 without done, the block SHALL go to ERROR in the next cycle, with err_layer=cur_layer and layer_start=0.
REQ-031 When done and timeout occur in the same cycle, done SHALL win.
REQ-032 abort in ISSUE, GAP, FINISH or ERROR SHALL, on the next cycle, return the block to IDLE with layer_start=0, busy=0, done=0 and error=0; run_cycles SHALL be held.
REQ-033 abort SHALL win over a simultaneous layer_done, timeout or start.
REQ-034 busy SHALL be 1 exactly in ISSUE and GAP.
REQ-035 run_cycles SHALL increment once per cycle with busy=1, saturating at 0xFFFF_FFFF.
REQ-036 done SHALL be 1 throughout FINISH, which SHALL hold until a new start or abort.
REQ-037 error SHALL be 1 throughout ERROR, which SHALL hold until a new start or abort.
REQ-038 A start accepted in FINISH or ERROR SHALL begin a fresh run per REQ-019.
REQ-039 cur_layer SHALL always index a non-skipped layer while busy.
REQ-040 The next-layer search SHALL be a priority scan above cur_layer completing in one cycle; it SHALL not wrap around.

Reset
REQ-041 While rst_n=0, the block SHALL be in IDLE with:
- layer_start=0, busy=0, done=0, error=0;
- err_layer=0, cur_layer=0, run_cycles=0;
- watchdog=0, latched skip_mask=0.
REQ-042 Reset asserted mid-run SHALL force these values immediately (asynchronously), with no further layer_start activity.
REQ-043 After rst_n deasserts, the block SHALL wait for a new start.

Verification (NUM_LAYERS=4, TIMEOUT_CYC=16)
REQ-044 Nominal run: start pulse at cycle 0, skip_mask=0; each layer asserts done 3 cycles after its start rises -> layer_start one-hot in order 0,1,2,3 with one all-zero GAP between layers; done=1 from cycle 16; run_cycles=15.
REQ-045 Skip: skip_mask=4'b0110 -> only layers 0 and 3 are started; cur_layer never equals 1 or 2; done=1 after layer 3's done.
REQ-046 Timeout: layer 2 never asserts done -> error=1 and err_layer=2 sixteen cycles after layer_start[2] rose; layer_start=0; done=0.
REQ-047 Abort race: abort and layer_done[1] both high in the same cycle -> IDLE next cycle; layer_start[2] never rises; busy=0; done=0.
REQ-048 Ignore rules:
- start re-pulsed mid-run -> no effect;
- spurious layer_done[3] while layer 0 is active -> ignored.
REQ-049 Reset during ISSUE of layer 1 -> all outputs are 0 in that cycle; a new start afterwards restarts from layer 0.
